// File: rtl/mod_mem_arbiter.sv
// mod_mem_arbiter: round-robin line-fill arbiter sharing one memory bus between I$ and D$,
// assembling the returned bus beats into one cache block per response.
module mod_mem_arbiter #(
  parameter int WORDSIZE = 64,
  parameter int LOGWIDTH = 6,
  parameter int TAGWIDTH = 13
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      ic_reqcyc,
  input  logic [63:0]               ic_req,
  input  logic [TAGWIDTH-1:0]       ic_reqtag,
  output logic                      ic_reqack,
  output logic                      ic_respcyc,
  output logic [(8<<LOGWIDTH)-1:0]  ic_resp,
  output logic [TAGWIDTH-1:0]       ic_resptag,
  input  logic                      ic_respack,
  input  logic                      dc_reqcyc,
  input  logic [63:0]               dc_req,
  input  logic [TAGWIDTH-1:0]       dc_reqtag,
  output logic                      dc_reqack,
  output logic                      dc_respcyc,
  output logic [(8<<LOGWIDTH)-1:0]  dc_resp,
  output logic [TAGWIDTH-1:0]       dc_resptag,
  input  logic                      dc_respack,
  output logic                      bus_reqcyc,
  output logic [63:0]               bus_req,
  output logic [TAGWIDTH-1:0]       bus_reqtag,
  input  logic                      bus_reqack,
  input  logic                      bus_respcyc,
  input  logic [WORDSIZE-1:0]       bus_resp,
  input  logic [TAGWIDTH-1:0]       bus_resptag,
  output logic                      bus_respack
);
  localparam int BLK   = 8 << LOGWIDTH;
  localparam int BEATS = BLK / WORDSIZE;
  localparam int CW    = $clog2(BEATS);
  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_BUS_REQ = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_DELIVER = 2'd3;
  logic [1:0]          r_state;
  logic                r_own_dc;
  logic                r_last_dc;
  logic [63:0]         r_addr;
  logic [TAGWIDTH-1:0] r_tag;
  logic [CW-1:0]       r_cnt;
  logic [BLK-1:0]      r_block;
  logic                r_ic_reqack;
  logic                r_dc_reqack;
  logic                w_gnt_ic;
  logic                w_beat_ok;
  logic                w_respack;
  logic                w_deliver;
  // On a tie the requester that did not win last time is served.
  assign w_gnt_ic  = ic_reqcyc & (~dc_reqcyc | r_last_dc);
  assign w_beat_ok = (r_state == S_WAIT) & bus_respcyc & (bus_resptag == r_tag);
  assign w_respack = r_own_dc ? dc_respack : ic_respack;
  assign w_deliver = r_state == S_DELIVER;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_own_dc    <= 1'b0;
      r_last_dc   <= 1'b1;
      r_addr      <= '0;
      r_tag       <= '0;
      r_cnt       <= '0;
      r_block     <= '0;
      r_ic_reqack <= 1'b0;
      r_dc_reqack <= 1'b0;
    end else begin
      r_ic_reqack <= 1'b0;
      r_dc_reqack <= 1'b0;
      case (r_state)
        S_IDLE: if (ic_reqcyc | dc_reqcyc) begin
          r_own_dc    <= ~w_gnt_ic;
          r_last_dc   <= ~w_gnt_ic;
          r_addr      <= w_gnt_ic ? ic_req : dc_req;
          r_tag       <= w_gnt_ic ? ic_reqtag : dc_reqtag;
          r_ic_reqack <= w_gnt_ic;
          r_dc_reqack <= ~w_gnt_ic;
          r_state     <= S_BUS_REQ;
        end
        S_BUS_REQ: if (bus_reqack) begin
          r_cnt   <= '0;
          r_state <= S_WAIT;
        end
        S_WAIT: if (w_beat_ok) begin
          r_block[r_cnt*WORDSIZE +: WORDSIZE] <= bus_resp;
          r_cnt <= r_cnt + 1'b1;
          if (r_cnt == CW'(BEATS-1)) r_state <= S_DELIVER;
        end
        S_DELIVER: if (w_respack) r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end
  assign ic_reqack   = r_ic_reqack;
  assign dc_reqack   = r_dc_reqack;
  assign ic_respcyc  = w_deliver & ~r_own_dc;
  assign dc_respcyc  = w_deliver & r_own_dc;
  assign ic_resp     = ic_respcyc ? r_block : '0;
  assign dc_resp     = dc_respcyc ? r_block : '0;
  assign ic_resptag  = ic_respcyc ? r_tag : '0;
  assign dc_resptag  = dc_respcyc ? r_tag : '0;
  assign bus_reqcyc  = r_state == S_BUS_REQ;
  assign bus_req     = r_addr;
  assign bus_reqtag  = r_tag;
  assign bus_respack = (r_state == S_WAIT) & bus_respcyc;
endmodule

// File: tb/tb_mod_mem_arbiter.sv
// tb_mod_mem_arbiter: directed self-checking bench for the I$/D$ memory arbiter.
module tb_mod_mem_arbiter;
  localparam int TW = 13;
  logic          clk = 1'b0;
  logic          reset;
  logic          ic_reqcyc, dc_reqcyc;
  logic [63:0]   ic_req, dc_req;
  logic [TW-1:0] ic_reqtag, dc_reqtag;
  logic          ic_reqack, dc_reqack, ic_respcyc, dc_respcyc;
  logic [511:0]  ic_resp, dc_resp;
  logic [TW-1:0] ic_resptag, dc_resptag;
  logic          ic_respack, dc_respack;
  logic          bus_reqcyc, bus_reqack, bus_respcyc, bus_respack;
  logic [63:0]   bus_req, bus_resp;
  logic [TW-1:0] bus_reqtag, bus_resptag;
  int n_cmp = 0;
  int n_bad = 0;
  always #5 clk = ~clk;
  mod_mem_arbiter dut (
    .clk(clk), .reset(reset),
    .ic_reqcyc(ic_reqcyc), .ic_req(ic_req), .ic_reqtag(ic_reqtag), .ic_reqack(ic_reqack),
    .ic_respcyc(ic_respcyc), .ic_resp(ic_resp), .ic_resptag(ic_resptag), .ic_respack(ic_respack),
    .dc_reqcyc(dc_reqcyc), .dc_req(dc_req), .dc_reqtag(dc_reqtag), .dc_reqack(dc_reqack),
    .dc_respcyc(dc_respcyc), .dc_resp(dc_resp), .dc_resptag(dc_resptag), .dc_respack(dc_respack),
    .bus_reqcyc(bus_reqcyc), .bus_req(bus_req), .bus_reqtag(bus_reqtag), .bus_reqack(bus_reqack),
    .bus_respcyc(bus_respcyc), .bus_resp(bus_resp), .bus_resptag(bus_resptag), .bus_respack(bus_respack)
  );
  task automatic chk(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask
  task automatic step;
    @(posedge clk);
    #1;
  endtask
  function automatic logic [511:0] blk(input logic [63:0] base);
    logic [511:0] b;
    for (int k = 0; k < 8; k++) b[64*k +: 64] = base + 64'(k);
    return b;
  endfunction
  task automatic grant(input bit exp_dc, input logic [63:0] addr, input logic [TW-1:0] tag);
    step;
    chk("ic_reqack", ic_reqack, !exp_dc);
    chk("dc_reqack", dc_reqack, exp_dc);
    chk("bus_reqcyc_on", bus_reqcyc, 1'b1);
    chk("bus_req", bus_req, addr);
    chk("bus_reqtag", bus_reqtag, tag);
  endtask
  task automatic bus_fill(input logic [TW-1:0] tag, input logic [63:0] base,
                          input int ack_dly, input int gap, input int bad);
    bus_reqack = 1'b0;
    for (int i = 0; i < ack_dly; i++) begin
      step;
      chk("bus_reqcyc_hold", bus_reqcyc, 1'b1);
    end
    bus_reqack = 1'b1;
    step;
    bus_reqack = 1'b0;
    chk("bus_reqcyc_off", bus_reqcyc, 1'b0);
    chk("reqack_pulse_end", {ic_reqack, dc_reqack}, 2'b00);
    for (int k = 0; k < 8; k++) begin
      if (gap > 0 && k % 2 == 1) begin
        bus_respcyc = 1'b0;
        repeat (gap) step;
      end
      if (k == bad) begin
        bus_respcyc = 1'b1;
        bus_resp    = 64'hDEAD_BEEF_DEAD_BEEF;
        bus_resptag = 13'h1F;
        #1;
        chk("bad_tag_acked", bus_respack, 1'b1);
        step;
      end
      bus_respcyc = 1'b1;
      bus_resp    = base + 64'(k);
      bus_resptag = tag;
      #1;
      chk("beat_ack", bus_respack, 1'b1);
      step;
    end
    bus_respcyc = 1'b0;
  endtask
  task automatic deliver(input bit dc, input logic [TW-1:0] tag, input logic [63:0] base, input int dly);
    for (int i = 0; i <= dly; i++) begin
      bus_respcyc = 1'b1;
      bus_resptag = tag;
      ic_respack  = !dc && (i == dly);
      dc_respack  = dc && (i == dly);
      #1;
      chk("owner_respcyc", dc ? dc_respcyc : ic_respcyc, 1'b1);
      chk("other_respcyc", dc ? ic_respcyc : dc_respcyc, 1'b0);
      chk("resp_block", dc ? dc_resp : ic_resp, blk(base));
      chk("resptag", dc ? dc_resptag : ic_resptag, tag);
      chk("stray_beat_noack", bus_respack, 1'b0);
      step;
    end
    bus_respcyc = 1'b0;
    ic_respack  = 1'b0;
    dc_respack  = 1'b0;
    chk("respcyc_drop", {ic_respcyc, dc_respcyc}, 2'b00);
  endtask
  task automatic do_reset;
    reset = 1'b1;
    {ic_reqcyc, dc_reqcyc, ic_respack, dc_respack, bus_reqack, bus_respcyc} = '0;
    ic_req = 64'h1000; ic_reqtag = 13'h05;
    dc_req = 64'h2000; dc_reqtag = 13'h0A;
    bus_resp = '0; bus_resptag = '0;
    step;
    step;
    reset = 1'b0;
  endtask
  initial begin
    do_reset;
    chk("rst_reqack", {ic_reqack, dc_reqack}, 2'b00);
    chk("rst_respcyc", {ic_respcyc, dc_respcyc}, 2'b00);
    chk("rst_bus_reqcyc", bus_reqcyc, 1'b0);
    chk("rst_bus_req", bus_req, 64'h0);
    chk("rst_bus_reqtag", bus_reqtag, 13'h0);
    chk("rst_resp", {ic_resp, dc_resp} == '0, 1'b1);
    chk("rst_resptag", {ic_resptag, dc_resptag}, 26'h0);
    // Single I-cache fill with beats 0..7.
    ic_reqcyc = 1'b1;
    grant(1'b0, 64'h1000, 13'h05);
    ic_reqcyc = 1'b0;
    bus_fill(13'h05, 64'h0, 0, 0, -1);
    chk("ic_resp_lo", ic_resp[63:0], 64'h0);
    chk("ic_resp_hi", ic_resp[511:448], 64'h7);
    chk("dc_respcyc_idle", dc_respcyc, 1'b0);
    deliver(1'b0, 13'h05, 64'h0, 0);
    // Simultaneous requests from reset: I, then D, then alternating while both stay asserted.
    do_reset;
    ic_reqcyc = 1'b1;
    dc_reqcyc = 1'b1;
    for (int i = 0; i < 5; i++) begin
      grant(i % 2 == 1, (i % 2 == 1) ? 64'h2000 : 64'h1000, (i % 2 == 1) ? 13'h0A : 13'h05);
      bus_fill((i % 2 == 1) ? 13'h0A : 13'h05, 64'h100 * (i + 1), 0, 0, -1);
      deliver(i % 2 == 1, (i % 2 == 1) ? 13'h0A : 13'h05, 64'h100 * (i + 1), 0);
    end
    ic_reqcyc = 1'b0;
    dc_reqcyc = 1'b0;
    // Gapped beats, late bus ack and one wrong-tag beat.
    ic_req = 64'h3000; ic_reqtag = 13'h07;
    ic_reqcyc = 1'b1;
    grant(1'b0, 64'h3000, 13'h07);
    ic_reqcyc = 1'b0;
    bus_fill(13'h07, 64'h5000, 2, 2, 3);
    deliver(1'b0, 13'h07, 64'h5000, 0);
    // Delayed respack; a request right after must be granted at once.
    dc_reqcyc = 1'b1;
    grant(1'b1, 64'h2000, 13'h0A);
    dc_reqcyc = 1'b0;
    bus_fill(13'h0A, 64'h7000, 0, 0, -1);
    deliver(1'b1, 13'h0A, 64'h7000, 5);
    ic_reqcyc = 1'b1;
    grant(1'b0, 64'h3000, 13'h07);
    ic_reqcyc = 1'b0;
    // Reset lands after beat 3 of this fill.
    bus_reqack = 1'b1;
    step;
    bus_reqack = 1'b0;
    for (int k = 0; k < 4; k++) begin
      bus_respcyc = 1'b1;
      bus_resp    = 64'hAA00 + 64'(k);
      bus_resptag = 13'h07;
      step;
    end
    reset = 1'b1;
    #1;
    chk("mid_rst_respack", bus_respack, 1'b0);
    chk("mid_rst_bus_reqcyc", bus_reqcyc, 1'b0);
    chk("mid_rst_bus_req", bus_req, 64'h0);
    chk("mid_rst_respcyc", {ic_respcyc, dc_respcyc}, 2'b00);
    step;
    reset = 1'b0;
    bus_respcyc = 1'b0;
    step;
    chk("post_rst_no_resp", {ic_respcyc, dc_respcyc}, 2'b00);
    dc_req = 64'h4000; dc_reqtag = 13'h0B;
    dc_reqcyc = 1'b1;
    grant(1'b1, 64'h4000, 13'h0B);
    dc_reqcyc = 1'b0;
    bus_fill(13'h0B, 64'h900, 0, 0, -1);
    deliver(1'b1, 13'h0B, 64'h900, 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
